// File: rtl/modn_event_counter.sv
// Modulo-N event counter with selectable direction, synchronous load,
// Mealy/Moore wrap ticks and a saturating wrap accumulator.
module modn_event_counter #(
    parameter int WIDTH      = 3,
    parameter int MODULUS    = 5,
    parameter int WRAP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  level,
    input  logic                  up,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    output logic [WIDTH-1:0]      count,
    output logic [WIDTH-1:0]      count_next,
    output logic                  mealy_tick,
    output logic                  moore_tick,
    output logic [WRAP_WIDTH-1:0] wrap_count,
    output logic                  wrap_sat
);

    generate
        if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
            $error("modn_event_counter: MODULUS out of range");
        end
    endgenerate

    // Top of range held in WIDTH bits so MODULUS = 2^WIDTH needs no extra bit
    localparam logic [WIDTH-1:0]      TOP      = WIDTH'(MODULUS - 1);
    localparam logic [WRAP_WIDTH-1:0] WRAP_MAX = '1;

    logic wrap_inc;

    always_comb begin
        count_next = count;
        mealy_tick = 1'b0;
        priority case (1'b1)
            reset: begin
                count_next = '0;
            end
            load: begin
                count_next = (load_value > TOP) ? TOP : load_value;
            end
            level: begin
                if (up) begin
                    if (count == TOP) begin
                        count_next = '0;
                        mealy_tick = 1'b1;
                    end else begin
                        count_next = count + WIDTH'(1);
                    end
                end else begin
                    if (count == '0) begin
                        count_next = TOP;
                        mealy_tick = 1'b1;
                    end else begin
                        count_next = count - WIDTH'(1);
                    end
                end
            end
            default: begin
                count_next = count;
            end
        endcase
    end

    assign wrap_inc = mealy_tick && (wrap_count != WRAP_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            moore_tick <= 1'b0;
            wrap_count <= '0;
            wrap_sat   <= 1'b0;
        end else begin
            count      <= count_next;
            moore_tick <= mealy_tick;
            if (wrap_inc) begin
                wrap_count <= wrap_count + WRAP_WIDTH'(1);
            end
            // Sticky flag rises on the edge that lands the accumulator on all-ones
            if (wrap_inc && (wrap_count == WRAP_MAX - WRAP_WIDTH'(1))) begin
                wrap_sat <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_modn_event_counter.sv
// Scoreboard bench for modn_event_counter: directed vectors drive three
// configurations; a monitor pops expected responses and compares.
module tb_modn_event_counter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic level = 1'b0;
    logic up = 1'b1;
    logic load = 1'b0;
    logic [2:0] load_value = 3'd0;

    logic [2:0] cnt_a, nxt_a, cnt_b, nxt_b, cnt_c, nxt_c;
    logic       me_a, mo_a, sat_a, me_b, mo_b, sat_b;
    logic       me_c, mo_c, sat_c;
    logic [7:0] wc_a, wc_c;
    logic [1:0] wc_b;

    always #5 clk = ~clk;

    modn_event_counter #(.WIDTH(3), .MODULUS(5), .WRAP_WIDTH(8)) u_a (
        .clk(clk), .reset(reset), .level(level), .up(up),
        .load(load), .load_value(load_value),
        .count(cnt_a), .count_next(nxt_a),
        .mealy_tick(me_a), .moore_tick(mo_a),
        .wrap_count(wc_a), .wrap_sat(sat_a)
    );

    modn_event_counter #(.WIDTH(3), .MODULUS(5), .WRAP_WIDTH(2)) u_b (
        .clk(clk), .reset(reset), .level(level), .up(up),
        .load(load), .load_value(load_value),
        .count(cnt_b), .count_next(nxt_b),
        .mealy_tick(me_b), .moore_tick(mo_b),
        .wrap_count(wc_b), .wrap_sat(sat_b)
    );

    modn_event_counter #(.WIDTH(3), .MODULUS(8), .WRAP_WIDTH(8)) u_c (
        .clk(clk), .reset(reset), .level(level), .up(up),
        .load(load), .load_value(load_value),
        .count(cnt_c), .count_next(nxt_c),
        .mealy_tick(me_c), .moore_tick(mo_c),
        .wrap_count(wc_c), .wrap_sat(sat_c)
    );

    typedef struct {
        int id;
        bit r, l, u, ld;
        int lv;
        int cnt, nxt;
        bit me, mo;
        int wc;
        bit sat;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    bit   drive_done = 1'b0;

    function automatic void add(int id, bit r, bit l, bit u, bit ld,
                                int lv, int cnt, int nxt, bit me,
                                bit mo, int wc, bit sat);
        vec_t v;
        v.id = id; v.r = r; v.l = l; v.u = u; v.ld = ld; v.lv = lv;
        v.cnt = cnt; v.nxt = nxt; v.me = me; v.mo = mo;
        v.wc = wc; v.sat = sat;
        vecs.push_back(v);
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(string name, int id, logic [31:0] act, int exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL dut%0d %s: got %0d expected %0d",
                      id, name, act, exp);
    endtask

    initial begin
        // Phase A: MODULUS=5, reset then count up 12 cycles
        add(0, 1,0,1,0,0, 0,0,0,0,0,0);
        add(0, 1,0,1,0,0, 0,0,0,0,0,0);
        add(0, 0,1,1,0,0, 0,1,0,0,0,0);
        add(0, 0,1,1,0,0, 1,2,0,0,0,0);
        add(0, 0,1,1,0,0, 2,3,0,0,0,0);
        add(0, 0,1,1,0,0, 3,4,0,0,0,0);
        add(0, 0,1,1,0,0, 4,0,1,0,0,0);
        add(0, 0,1,1,0,0, 0,1,0,1,1,0);
        add(0, 0,1,1,0,0, 1,2,0,0,1,0);
        add(0, 0,1,1,0,0, 2,3,0,0,1,0);
        add(0, 0,1,1,0,0, 3,4,0,0,1,0);
        add(0, 0,1,1,0,0, 4,0,1,0,1,0);
        add(0, 0,1,1,0,0, 0,1,0,1,2,0);
        add(0, 0,1,1,0,0, 1,2,0,0,2,0);
        // load 0, then count down and hold
        add(0, 0,1,1,1,0, 2,0,0,0,2,0);
        add(0, 0,1,0,0,0, 0,4,1,0,2,0);
        add(0, 0,1,0,0,0, 4,3,0,1,3,0);
        add(0, 0,0,0,0,0, 3,3,0,0,3,0);
        add(0, 0,0,0,0,0, 3,3,0,0,3,0);
        add(0, 0,0,0,0,0, 3,3,0,0,3,0);
        // load and clamp, load in a would-be-wrap cycle
        add(0, 0,0,1,1,2, 3,2,0,0,3,0);
        add(0, 0,0,1,1,7, 2,4,0,0,3,0);
        add(0, 0,1,1,1,1, 4,1,0,0,3,0);
        add(0, 0,1,1,0,0, 1,2,0,0,3,0);
        add(0, 0,1,1,0,0, 2,3,0,0,3,0);
        add(0, 0,1,1,0,0, 3,4,0,0,3,0);
        // reset (with load) at count=4 while level=1
        add(0, 1,1,1,1,3, 4,0,0,0,3,0);
        add(0, 0,0,1,0,0, 0,0,0,0,0,0);

        // Phase B: WRAP_WIDTH=2 saturation, 25 cycles
        add(-1, 1,0,1,0,0, 0,0,0,0,0,0);
        add(1,  1,0,1,0,0, 0,0,0,0,0,0);
        for (int k = 0; k < 25; k++) begin
            add(1, 0,1,1,0,0, k % 5, (k + 1) % 5, (k % 5) == 4,
                (k > 0) && ((k % 5) == 0), imin(k / 5, 3), k >= 15);
        end
        add(1, 1,1,1,0,0, 0,0,0,1,3,1);
        add(1, 0,0,1,0,0, 0,0,0,0,0,0);

        // Phase C: MODULUS=8 full range
        add(-1, 1,0,1,0,0, 0,0,0,0,0,0);
        add(2,  1,0,1,0,0, 0,0,0,0,0,0);
        for (int k = 0; k < 9; k++) begin
            add(2, 0,1,1,0,0, k % 8, (k + 1) % 8, k == 7,
                k == 8, (k == 8) ? 1 : 0, 0);
        end
        add(2, 0,1,1,1,0, 1,0,0,0,1,0);
        add(2, 0,1,0,0,0, 0,7,1,0,1,0);
        add(2, 0,1,0,0,0, 7,6,0,1,2,0);
        add(2, 0,1,0,0,0, 6,5,0,0,2,0);
        add(2, 0,0,1,1,7, 5,7,0,0,2,0);
        add(2, 0,0,1,0,0, 7,7,0,0,2,0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            reset      = vecs[i].r;
            level      = vecs[i].l;
            up         = vecs[i].u;
            load       = vecs[i].ld;
            load_value = 3'(vecs[i].lv);
            if (vecs[i].id >= 0) exp_q.push_back(vecs[i]);
        end
        drive_done = 1'b1;
    end

    initial begin : monitor
        vec_t e;
        logic [2:0] c, n;
        logic       me, mo, s;
        logic [7:0] w;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.id)
                    0: begin
                        c = cnt_a; n = nxt_a; me = me_a; mo = mo_a;
                        w = wc_a; s = sat_a;
                    end
                    1: begin
                        c = cnt_b; n = nxt_b; me = me_b; mo = mo_b;
                        w = {6'd0, wc_b}; s = sat_b;
                    end
                    default: begin
                        c = cnt_c; n = nxt_c; me = me_c; mo = mo_c;
                        w = wc_c; s = sat_c;
                    end
                endcase
                chk("count", e.id, 32'(c), e.cnt);
                chk("count_next", e.id, 32'(n), e.nxt);
                chk("mealy_tick", e.id, 32'(me), int'(e.me));
                chk("moore_tick", e.id, 32'(mo), int'(e.mo));
                chk("wrap_count", e.id, 32'(w), e.wc);
                chk("wrap_sat", e.id, 32'(s), int'(e.sat));
            end
        end
    end

    initial begin : finisher
        int guard;
        guard = 0;
        while (!(drive_done && exp_q.size() == 0) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        if (guard >= 2000) begin
            n_total++;
            $display("FAIL timeout: drained=%0d expected 1", exp_q.size() == 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
